masked_hpc3_rand_source: RTL and testbench

Fresh-randomness source sitting directly upstream of the parallel HPC3 multiplier stage. It produces the per-cycle refresh masks (`r`, `p_ab`, `p_ac`) consumed by the two HPC3 multipliers, using seeded xorshift32 lanes with a warm-up phase. It exposes a valid/ready handshake and raises a reseed request after a configurable number of consumed words.

---
 rtl/masked_hpc3_rand_source.sv | 154 +++++++++++++++
 tb/tb_masked_hpc3_rand_source.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/masked_hpc3_rand_source.sv
// Fresh-randomness source for the parallel HPC3 multiplier stage.
// K xorshift32 lanes are seeded from a 32-bit value, run through a warm-up
// phase, then stepped once per consumed word.  The r / p_ab / p_ac refresh
// masks are sliced straight out of the lane registers.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | after reset, no seed yet; outputs invalid, in_ready ignored
// WARMUP | seed loaded, discarding wc generator steps
// RUN    | words valid; lanes step on every accepted in_ready
module masked_hpc3_rand_source #(
    parameter int NUM_SHARES      = 2,
    parameter int BIT_WIDTH       = 4,
    parameter int WARMUP_CYCLES   = 16,
    parameter int RESEED_INTERVAL = 1024
) (
    input  logic                                                      in_clock,
    input  logic                                                      in_reset,
    input  logic [31:0]                                               in_seed,
    input  logic                                                      in_seed_valid,
    input  logic                                                      in_ready,
    output logic                                                      out_valid,
    output logic [NUM_SHARES*(NUM_SHARES-1)/2-1:0][BIT_WIDTH-1:0]     out_r,
    output logic [NUM_SHARES*(NUM_SHARES-1)/2-1:0][BIT_WIDTH-1:0]     out_p_ab,
    output logic [NUM_SHARES*(NUM_SHARES-1)/2-1:0][BIT_WIDTH-1:0]     out_p_ac,
    output logic                                                      out_reseed_req
);

    localparam int Q    = NUM_SHARES * (NUM_SHARES - 1) / 2;
    localparam int QW   = Q * BIT_WIDTH;
    localparam int RW   = 3 * QW;
    localparam int K    = (RW + 31) / 32;
    localparam int WC_W = (WARMUP_CYCLES > 0) ? $clog2(WARMUP_CYCLES + 1) : 1;
    localparam int CC_W = $clog2(RESEED_INTERVAL + 1);

    localparam logic [WC_W-1:0] WC_INIT = WC_W'(WARMUP_CYCLES);
    localparam logic [CC_W-1:0] CC_MAX  = CC_W'(RESEED_INTERVAL);
    localparam logic [31:0]     GOLDEN  = 32'h9E3779B9;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WARMUP = 2'd1,
        S_RUN    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       lane_q [K];
    logic [31:0]       lane_d [K];
    logic [WC_W-1:0]   wc_q, wc_d;
    logic [CC_W-1:0]   cc_q, cc_d;
    logic              req_q, req_d;
    logic [RW-1:0]     s_flat;

    function automatic logic [31:0] xs_step(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    // An all-zero lane would lock xorshift at zero forever, so it is replaced by 1.
    function automatic logic [31:0] seed_lane(input logic [31:0] seed, input int unsigned k);
        logic [31:0] v;
        v = seed ^ (32'(k) * GOLDEN);
        if (v == 32'h0) begin
            v = 32'h1;
        end
        return v;
    endfunction

    // State, lane and counter registers; reset forces every output to zero.
    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            state_q <= S_IDLE;
            for (int k = 0; k < K; k++) begin
                lane_q[k] <= '0;
            end
            wc_q    <= '0;
            cc_q    <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            wc_q    <= wc_d;
            cc_q    <= cc_d;
            req_q   <= req_d;
        end
    end

    // Next-state logic: a seed load overrides everything, including in_ready.
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        wc_d    = wc_q;
        cc_d    = cc_q;
        req_d   = req_q;
        if (in_seed_valid) begin
            for (int k = 0; k < K; k++) begin
                lane_d[k] = seed_lane(in_seed, k);
            end
            wc_d    = WC_INIT;
            cc_d    = '0;
            req_d   = 1'b0;
            state_d = S_WARMUP;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_WARMUP: begin
                    if (wc_q == '0) begin
                        state_d = S_RUN;
                    end else begin
                        for (int k = 0; k < K; k++) begin
                            lane_d[k] = xs_step(lane_q[k]);
                        end
                        wc_d = wc_q - 1'b1;
                    end
                end
                S_RUN: begin
                    if (in_ready) begin
                        for (int k = 0; k < K; k++) begin
                            lane_d[k] = xs_step(lane_q[k]);
                        end
                        // Saturate so the request stays meaningful after the interval.
                        if (cc_q != CC_MAX) begin
                            cc_d = cc_q + 1'b1;
                        end
                        if (cc_d == CC_MAX) begin
                            req_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Concatenate the lanes LSB-first, keeping only the bits the masks use.
    for (genvar k = 0; k < K; k++) begin : g_map
        localparam int CHUNK = ((RW - 32 * k) > 32) ? 32 : (RW - 32 * k);
        assign s_flat[32*k +: CHUNK] = lane_q[k][CHUNK-1:0];
    end

    assign out_r          = s_flat[QW-1:0];
    assign out_p_ab       = s_flat[2*QW-1:QW];
    assign out_p_ac       = s_flat[RW-1:2*QW];
    assign out_valid      = (state_q == S_RUN);
    assign out_reseed_req = req_q;

endmodule

// File: tb/tb_masked_hpc3_rand_source.sv
// Bench for masked_hpc3_rand_source: two instances (single-lane Q=1 with a
// short reseed interval, and three-lane Q=3 with no warm-up) checked against
// an arithmetic xorshift32 reference model.
module tb_masked_hpc3_rand_source;

    localparam int A_W  = 1;
    localparam int A_RI = 4;
    localparam int B_W  = 0;
    localparam int B_RI = 1024;
    localparam longint unsigned M32 = 64'h1_0000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic [31:0]     a_seed;
    logic            a_seed_valid, a_ready, a_valid, a_req;
    logic [0:0][3:0] a_r, a_p_ab, a_p_ac;

    logic [31:0]     b_seed;
    logic            b_seed_valid, b_ready, b_valid, b_req;
    logic [2:0][7:0] b_r, b_p_ab, b_p_ac;

    int checks   = 0;
    int failures = 0;

    // Reference model: phase 0 idle, 1 warm-up, 2 running.
    logic [31:0] ma;
    int          ma_ph, ma_wc, ma_cnt;
    logic [31:0] mb [3];
    int          mb_ph, mb_wc, mb_cnt;

    masked_hpc3_rand_source #(
        .NUM_SHARES(2), .BIT_WIDTH(4), .WARMUP_CYCLES(A_W), .RESEED_INTERVAL(A_RI)
    ) dut_a (
        .in_clock(clk), .in_reset(rst_n), .in_seed(a_seed), .in_seed_valid(a_seed_valid),
        .in_ready(a_ready), .out_valid(a_valid), .out_r(a_r), .out_p_ab(a_p_ab),
        .out_p_ac(a_p_ac), .out_reseed_req(a_req)
    );

    masked_hpc3_rand_source #(
        .NUM_SHARES(3), .BIT_WIDTH(8), .WARMUP_CYCLES(B_W), .RESEED_INTERVAL(B_RI)
    ) dut_b (
        .in_clock(clk), .in_reset(rst_n), .in_seed(b_seed), .in_seed_valid(b_seed_valid),
        .in_ready(b_ready), .out_valid(b_valid), .out_r(b_r), .out_p_ab(b_p_ab),
        .out_p_ac(b_p_ac), .out_reseed_req(b_req)
    );

    function automatic logic [31:0] ref_step(input logic [31:0] x);
        longint unsigned v;
        v = x;
        v = v ^ ((v * 64'd8192) % M32);
        v = v ^ (v / 64'd131072);
        v = v ^ ((v * 64'd32) % M32);
        return v[31:0];
    endfunction

    function automatic logic [31:0] ref_seed(input logic [31:0] s, input int k);
        longint unsigned p;
        logic [31:0]     v;
        p = (longint'(k) * 64'h9E3779B9) % M32;
        v = s ^ p[31:0];
        return (v == 32'h0) ? 32'h1 : v;
    endfunction

    function automatic logic [13:0] exp_a();
        return {ma_ph == 2, ma_cnt >= A_RI, ma[11:0]};
    endfunction

    function automatic logic [13:0] act_a();
        return {a_valid, a_req, a_p_ac, a_p_ab, a_r};
    endfunction

    function automatic logic [73:0] exp_b();
        logic [95:0] s;
        s = {mb[2], mb[1], mb[0]};
        return {mb_ph == 2, mb_cnt >= B_RI, s[71:0]};
    endfunction

    function automatic logic [73:0] act_b();
        return {b_valid, b_req, b_p_ac, b_p_ab, b_r};
    endfunction

    task automatic model_reset();
        ma = '0; ma_ph = 0; ma_wc = 0; ma_cnt = 0;
        for (int k = 0; k < 3; k++) mb[k] = '0;
        mb_ph = 0; mb_wc = 0; mb_cnt = 0;
    endtask

    task automatic model_tick();
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (a_seed_valid) begin
            ma = ref_seed(a_seed, 0); ma_ph = 1; ma_wc = A_W; ma_cnt = 0;
        end else if (ma_ph == 1) begin
            if (ma_wc == 0) ma_ph = 2;
            else begin ma = ref_step(ma); ma_wc--; end
        end else if (ma_ph == 2 && a_ready) begin
            ma = ref_step(ma); ma_cnt++;
        end
        if (b_seed_valid) begin
            for (int k = 0; k < 3; k++) mb[k] = ref_seed(b_seed, k);
            mb_ph = 1; mb_wc = B_W; mb_cnt = 0;
        end else if (mb_ph == 1) begin
            if (mb_wc == 0) mb_ph = 2;
            else begin for (int k = 0; k < 3; k++) mb[k] = ref_step(mb[k]); mb_wc--; end
        end else if (mb_ph == 2 && b_ready) begin
            for (int k = 0; k < 3; k++) mb[k] = ref_step(mb[k]);
            mb_cnt++;
        end
    endtask

    // Advance one clock; inputs currently driven are the ones sampled.
    task automatic cyc();
        model_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (act_a() !== 14'h0) begin failures++; $display("FAIL reset_a: got %h expected %h", act_a(), 14'h0); end
        checks++;
        if (act_b() !== 74'h0) begin failures++; $display("FAIL reset_b: got %h expected %h", act_b(), 74'h0); end
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        a_ready = 1'b1; b_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (act_a() !== 14'h0) begin failures++; $display("FAIL idle_a: got %h expected %h", act_a(), 14'h0); end
            checks++;
            if (act_b() !== 74'h0) begin failures++; $display("FAIL idle_b: got %h expected %h", act_b(), 74'h0); end
        end
        a_ready = 1'b0; b_ready = 1'b0;
    endtask

    task automatic test_basic();
        a_seed = 32'h1; a_seed_valid = 1'b1;
        cyc();
        a_seed_valid = 1'b0;
        for (int i = 1; i <= A_W + 1; i++) begin
            checks++;
            if (a_valid !== 1'b0) begin failures++; $display("FAIL basic_warm_valid: got %b expected 0", a_valid); end
            cyc();
        end
        checks++;
        if ({a_valid, a_p_ac, a_p_ab, a_r} !== {1'b1, 4'h0, 4'h2, 4'h1})
            begin failures++; $display("FAIL basic_word: got %h expected %h", {a_valid, a_p_ac, a_p_ab, a_r}, {1'b1, 12'h021}); end
        checks++;
        if (act_a() !== exp_a()) begin failures++; $display("FAIL basic_model: got %h expected %h", act_a(), exp_a()); end
    endtask

    task automatic test_stall_stream();
        a_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            checks++;
            if ({a_valid, a_p_ac, a_p_ab, a_r} !== {1'b1, 12'h021})
                begin failures++; $display("FAIL stall_hold: got %h expected %h", {a_valid, a_p_ac, a_p_ab, a_r}, {1'b1, 12'h021}); end
        end
        a_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            checks++;
            if (act_a() !== exp_a()) begin failures++; $display("FAIL stream_word%0d: got %h expected %h", i, act_a(), exp_a()); end
        end
        a_ready = 1'b0;
    endtask

    task automatic test_zero_seed();
        a_seed = 32'h0; a_seed_valid = 1'b1;
        b_seed = 32'h0; b_seed_valid = 1'b1;
        cyc();
        a_seed_valid = 1'b0; b_seed_valid = 1'b0;
        checks++;
        if (b_valid !== 1'b0) begin failures++; $display("FAIL zero_b_warm: got %b expected 0", b_valid); end
        cyc();
        checks++;
        if ({b_valid, b_p_ac, b_p_ab, b_r} !== {1'b1, 72'h729E37_79B900_000001})
            begin failures++; $display("FAIL zero_b_word: got %h expected %h", {b_valid, b_p_ac, b_p_ab, b_r}, {1'b1, 72'h729E37_79B900_000001}); end
        cyc();
        checks++;
        if ({a_valid, a_p_ac, a_p_ab, a_r} !== {1'b1, 12'h021})
            begin failures++; $display("FAIL zero_a_word: got %h expected %h", {a_valid, a_p_ac, a_p_ab, a_r}, {1'b1, 12'h021}); end
        b_seed = 32'h9E3779B9; b_seed_valid = 1'b1;
        cyc();
        b_seed_valid = 1'b0;
        cyc();
        checks++;
        if ({b_valid, b_p_ac, b_p_ab, b_r} !== {1'b1, 72'hCB0000_00019E_3779B9})
            begin failures++; $display("FAIL lane1_zero_word: got %h expected %h", {b_valid, b_p_ac, b_p_ab, b_r}, {1'b1, 72'hCB0000_00019E_3779B9}); end
        checks++;
        if (act_b() !== exp_b()) begin failures++; $display("FAIL lane1_zero_model: got %h expected %h", act_b(), exp_b()); end
    endtask

    task automatic test_reseed_req();
        a_seed = $urandom; a_seed_valid = 1'b1;
        cyc();
        a_seed_valid = 1'b0;
        cyc(); cyc();
        a_ready = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            cyc();
            checks++;
            if (a_req !== (i >= A_RI)) begin failures++; $display("FAIL req_after_%0d: got %b expected %b", i, a_req, i >= A_RI); end
            checks++;
            if (act_a() !== exp_a()) begin failures++; $display("FAIL req_model_%0d: got %h expected %h", i, act_a(), exp_a()); end
        end
        a_ready = 1'b0;
        a_seed = $urandom; a_seed_valid = 1'b1;
        cyc();
        a_seed_valid = 1'b0;
        checks++;
        if ({a_valid, a_req} !== 2'b00) begin failures++; $display("FAIL reseed_clear: got %b expected 00", {a_valid, a_req}); end
        for (int i = 0; i < A_W + 1; i++) begin
            cyc();
            checks++;
            if (act_a() !== exp_a()) begin failures++; $display("FAIL reseed_warm%0d: got %h expected %h", i, act_a(), exp_a()); end
        end
        checks++;
        if (a_valid !== 1'b1) begin failures++; $display("FAIL reseed_valid_back: got %b expected 1", a_valid); end
    endtask

    task automatic test_seed_ready_collision();
        logic [31:0] s;
        s = $urandom | 32'h1;
        a_seed = s; a_seed_valid = 1'b1; a_ready = 1'b1;
        cyc();
        a_seed_valid = 1'b0;
        checks++;
        if ({a_valid, a_req, a_p_ac, a_p_ab, a_r} !== {2'b00, s[11:0]})
            begin failures++; $display("FAIL collide_load: got %h expected %h", act_a(), {2'b00, s[11:0]}); end
        for (int i = 0; i < A_W + 1 + A_RI; i++) begin
            cyc();
            checks++;
            if (act_a() !== exp_a()) begin failures++; $display("FAIL collide_run%0d: got %h expected %h", i, act_a(), exp_a()); end
        end
        a_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [71:0] prev;
        b_ready = 1'b1;
        prev = {b_p_ac, b_p_ab, b_r};
        for (int i = 0; i < 10; i++) begin
            cyc();
            checks++;
            if (act_b() !== exp_b()) begin failures++; $display("FAIL b2b_word%0d: got %h expected %h", i, act_b(), exp_b()); end
            checks++;
            if ({b_p_ac, b_p_ab, b_r} === prev) begin failures++; $display("FAIL b2b_fresh%0d: got %h expected change from %h", i, {b_p_ac, b_p_ab, b_r}, prev); end
            prev = {b_p_ac, b_p_ab, b_r};
        end
        b_ready = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            a_ready = 1'($urandom_range(1));
            b_ready = 1'($urandom_range(1));
            a_seed_valid = ($urandom_range(15) == 0);
            b_seed_valid = ($urandom_range(20) == 0);
            a_seed = $urandom;
            b_seed = $urandom;
            cyc();
            checks++;
            if (act_a() !== exp_a()) begin failures++; $display("FAIL rand_a%0d: got %h expected %h", i, act_a(), exp_a()); end
            checks++;
            if (act_b() !== exp_b()) begin failures++; $display("FAIL rand_b%0d: got %h expected %h", i, act_b(), exp_b()); end
        end
        a_ready = 1'b0; b_ready = 1'b0; a_seed_valid = 1'b0; b_seed_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        b_seed = $urandom; b_seed_valid = 1'b1;
        cyc();
        b_seed_valid = 1'b0;
        a_seed = $urandom | 32'h100; a_seed_valid = 1'b1;
        cyc();
        a_seed_valid = 1'b0;
        checks++;
        if ({a_valid, b_valid} !== 2'b01) begin failures++; $display("FAIL pre_reset_phase: got %b expected 01", {a_valid, b_valid}); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (act_a() !== 14'h0) begin failures++; $display("FAIL rst_mid_warm_a: got %h expected %h", act_a(), 14'h0); end
        checks++;
        if (act_b() !== 74'h0) begin failures++; $display("FAIL rst_mid_run_b: got %h expected %h", act_b(), 74'h0); end
        a_ready = 1'b1; b_ready = 1'b1;
        cyc();
        checks++;
        if ({act_a(), act_b()} !== 88'h0) begin failures++; $display("FAIL rst_held: got %h expected 0", {act_a(), act_b()}); end
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if ({act_a(), act_b()} !== 88'h0) begin failures++; $display("FAIL post_rst_idle%0d: got %h expected 0", i, {act_a(), act_b()}); end
        end
        a_seed = $urandom; a_seed_valid = 1'b1;
        cyc();
        a_seed_valid = 1'b0;
        cyc(); cyc(); cyc();
        checks++;
        if (act_a() !== exp_a()) begin failures++; $display("FAIL pre_rst_run_a: got %h expected %h", act_a(), exp_a()); end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (act_a() !== 14'h0) begin failures++; $display("FAIL rst_mid_run_a: got %h expected %h", act_a(), 14'h0); end
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc();
        checks++;
        if (act_a() !== 14'h0) begin failures++; $display("FAIL post_rst_run_idle: got %h expected %h", act_a(), 14'h0); end
        a_ready = 1'b0; b_ready = 1'b0;
    endtask

    initial begin
        a_seed = '0; a_seed_valid = 1'b0; a_ready = 1'b0;
        b_seed = '0; b_seed_valid = 1'b0; b_ready = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_stall_stream();
        test_zero_seed();
        test_reseed_req();
        test_seed_ready_collision();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
